// File: rtl/ram_port_initiator.sv
// ram_port_initiator: burst command engine driving a single synchronous RAM port
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_we,
//   cmd_addr, cmd_len                 burst command (len = beats - 1)
//   wr_valid/wr_ready, wr_data        write beat handshake
//   rd_valid, rd_data, rd_last        read beat output, one-cycle pulse
//   busy                              engine not idle
//   ram_cs, ram_oe, ram_we,
//   ram_address, ram_din, ram_dout    registered RAM port
module ram_port_initiator #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [3:0]               cmd_len,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     ram_cs,
    output logic                     ram_oe,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);
    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_CAPTURE} state_t;
    state_t                   state, state_d;
    logic [ADDRESS_WIDTH-1:0] addr, addr_d, ram_address_d;
    logic [3:0]               cnt, cnt_d;
    logic [DATA_WIDTH-1:0]    ram_din_d, rd_data_d;
    logic                     ram_cs_d, ram_oe_d, ram_we_d, rd_valid_d, rd_last_d;
    assign cmd_ready = (state == IDLE) && !rst;
    assign wr_ready  = state == WR;
    assign busy      = state != IDLE;
    // Outputs are computed one cycle ahead so the strobe is visible in the
    // cycle of the state it belongs to (read strobe during RD_ISSUE, write
    // strobe in the cycle after the beat handshake).
    always_comb begin
        state_d       = state;
        addr_d        = addr;
        cnt_d         = cnt;
        ram_cs_d      = 1'b0;
        ram_oe_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_address_d = ram_address;
        ram_din_d     = ram_din;
        rd_valid_d    = 1'b0;
        rd_last_d     = 1'b0;
        rd_data_d     = rd_data;
        case (state)
            IDLE: if (cmd_valid && cmd_ready) begin
                cnt_d   = cmd_len;
                addr_d  = cmd_addr;
                state_d = cmd_we ? WR : RD_ISSUE;
                if (!cmd_we) begin
                    ram_cs_d      = 1'b1;
                    ram_oe_d      = 1'b1;
                    ram_address_d = cmd_addr;
                end
            end
            WR: if (wr_valid) begin
                ram_cs_d      = 1'b1;
                ram_we_d      = 1'b1;
                ram_address_d = addr;
                ram_din_d     = wr_data;
                addr_d        = addr + 1'b1;
                cnt_d         = cnt - 4'd1;
                state_d       = (cnt == 4'd0) ? IDLE : WR;
            end
            RD_ISSUE: state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                rd_valid_d = 1'b1;
                rd_data_d  = ram_dout;
                rd_last_d  = cnt == 4'd0;
                state_d    = (cnt == 4'd0) ? IDLE : RD_ISSUE;
                if (cnt != 4'd0) begin
                    cnt_d         = cnt - 4'd1;
                    addr_d        = addr + 1'b1;
                    ram_cs_d      = 1'b1;
                    ram_oe_d      = 1'b1;
                    ram_address_d = addr + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            cnt         <= '0;
            ram_cs      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_din     <= '0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_d;
            addr        <= addr_d;
            cnt         <= cnt_d;
            ram_cs      <= ram_cs_d;
            ram_oe      <= ram_oe_d;
            ram_we      <= ram_we_d;
            ram_address <= ram_address_d;
            ram_din     <= ram_din_d;
            rd_valid    <= rd_valid_d;
            rd_last     <= rd_last_d;
            rd_data     <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_ram_port_initiator.sv
// tb_ram_port_initiator: scoreboard bench with RAM model and reference memory
module tb_ram_port_initiator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_we = 1'b0, wr_valid = 1'b0;
    logic [7:0] cmd_addr = '0, wr_data = '0, ram_dout;
    logic [3:0] cmd_len = '0;
    logic       cmd_ready, wr_ready, rd_valid, rd_last, busy, ram_cs, ram_oe, ram_we;
    logic [7:0] rd_data, ram_address, ram_din;
    int         compared = 0, mismatched = 0, cyc = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [15:0] wq [$];
    logic [8:0]  rq [$];
    int          st_q [$];

    ram_port_initiator dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_address(ram_address), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // RAM model: synchronous write, registered read data the cycle after a read strobe
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        ram_dout = '0;
        forever begin
            @(posedge clk);
            if (ram_cs && ram_we) mem[ram_address] <= ram_din;
            if (ram_cs && ram_oe) ram_dout <= mem[ram_address];
        end
    end

    // Monitor: pops expected strobes and read beats, checks latency and invariants
    initial forever begin
        @(negedge clk);
        cyc++;
        chk("we_oe_exclusive", 32'(ram_we && ram_oe), 0);
        chk("cs_low_quiet", 32'(!ram_cs && (ram_we || ram_oe)), 0);
        chk("ready_while_busy", 32'(cmd_ready && busy), 0);
        if (ram_cs && ram_oe) st_q.push_back(cyc);
        if (ram_cs && ram_we) begin
            chk("wr_strobe_expected", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) chk("wr_strobe_addr_data", {ram_address, ram_din}, wq.pop_front());
        end
        if (rd_valid) begin
            chk("rd_beat_expected", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) chk("rd_data_last", {rd_data, rd_last}, rq.pop_front());
            chk("rd_strobe_seen", 32'(st_q.size() != 0), 1);
            if (st_q.size() != 0) chk("rd_latency", 32'(cyc - st_q.pop_front()), 2);
        end
    end

    task automatic issue(input logic we, input logic [7:0] a, input logic [3:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
        while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("cmd_accept_timeout", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [7:0] a, input int len, input int gap,
                            input logic [7:0] base, input bit rnd);
        logic [7:0] d [16];
        for (int i = 0; i <= len; i++) begin
            d[i] = rnd ? 8'($urandom) : 8'(base + i);
            ref_mem[8'(a + i)] = d[i];
            wq.push_back({8'(a + i), d[i]});
        end
        issue(1'b1, a, 4'(len));
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            wr_valid = 1'b1; wr_data = d[i];
            while (!wr_ready && n < 50) begin @(posedge clk); #1; n++; end
            chk("wr_ready_timeout", 32'(wr_ready), 1);
            @(posedge clk); #1;
            wr_valid = 1'b0;
            if (i != len) repeat (gap) begin @(posedge clk); #1; end
        end
        chk("wr_done_idle", 32'(busy), 0);
    endtask

    task automatic rd_burst(input logic [7:0] a, input int len);
        int n = 0;
        for (int i = 0; i <= len; i++) rq.push_back({ref_mem[8'(a + i)], i == len});
        issue(1'b0, a, 4'(len));
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        chk("rd_busy_cycles", 32'(n), 32'(2 * (len + 1)));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        #2;
        chk("reset_outputs", {ram_cs, ram_oe, ram_we, ram_address, ram_din, rd_valid, rd_data,
                              rd_last, wr_ready, busy, cmd_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_reset", 32'(cmd_ready), 1);
        wr_burst(8'h10, 3, 0, 8'hA1, 1'b0);
        rd_burst(8'h10, 3);
        wr_burst(8'hFE, 2, 0, 8'h55, 1'b0);
        rd_burst(8'hFE, 2);
        wr_burst(8'h40, 3, 2, 8'h00, 1'b1);
        rd_burst(8'h40, 3);
        wr_burst(8'h80, 0, 0, 8'h00, 1'b1);
        rd_burst(8'h80, 0);
        wr_burst(8'hF8, 15, 1, 8'h00, 1'b1);
        rd_burst(8'hF8, 15);
        for (int k = 0; k < 25; k++) begin
            logic [7:0] a = 8'($urandom);
            int len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) wr_burst(a, len, int'($urandom_range(0, 2)), 8'h00, 1'b1);
            else rd_burst(a, len);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        // Abandon a 4-beat read while its second beat is being issued
        issue(1'b0, 8'h10, 4'd3);
        repeat (2) begin @(posedge clk); #1; end
        #1 rst = 1'b1;
        #1 chk("midburst_reset_outputs", {ram_cs, ram_oe, ram_we, ram_address, ram_din, rd_valid,
                                          rd_data, rd_last, wr_ready, busy, cmd_ready}, 0);
        rq.delete(); st_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("idle_after_reset", 32'(busy), 0);
        rd_burst(8'h10, 3);
        wr_burst(8'h20, 1, 0, 8'h00, 1'b1);
        rd_burst(8'h20, 1);
        repeat (4) begin @(posedge clk); #1; end
        chk("wr_queue_drained", 32'(wq.size()), 0);
        chk("rd_queue_drained", 32'(rq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_port_initiator.md
RAM_PORT_INITIATOR -- requirements
Module: ram_port_initiator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, RAM address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  burst command offered.
REQ-006 cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-007 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  ADDRESS_WIDTH  first beat address.
REQ-009 cmd_len  in  4  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-010 wr_valid / wr_ready  in / out  1 / 1  write-data handshake.
REQ-011 wr_data  in  DATA_WIDTH  write beat data.
REQ-012 rd_valid  out  1  read beat data valid, one-cycle pulse, no backpressure.
REQ-013 rd_data  out  DATA_WIDTH  read beat data.
REQ-014 rd_last  out  1  high with rd_valid on final read beat.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 ram_cs, ram_oe, ram_we  out  1 each  RAM port controls.
REQ-017 ram_address  out  ADDRESS_WIDTH  RAM port address.
REQ-018 ram_din  out  DATA_WIDTH  RAM port write data.
REQ-019 ram_dout  in  DATA_WIDTH  RAM port read data, valid the cycle after a read strobe while ram_address is held.

Function
REQ-020 All ram_* outputs, rd_data, rd_valid, rd_last SHALL be registered.
REQ-021 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_CAPTURE.
REQ-022 cmd_ready SHALL equal (state == IDLE); cmd_valid && cmd_ready SHALL latch cmd_addr, cmd_len, cmd_we and go to WR (cmd_we=1) or RD_ISSUE (cmd_we=0).
REQ-023 In WR, wr_ready SHALL be 1; elsewhere 0.
REQ-024 Each wr_valid && wr_ready edge SHALL drive, for exactly the next cycle, ram_cs=1, ram_we=1, ram_oe=0, ram_address=current address, ram_din=wr_data; one beat per cycle sustained.
REQ-025 Cycles in WR without wr_valid SHALL drive ram_cs=0, ram_we=0 (stall, no write).
REQ-026 After the final write beat is accepted, state SHALL return to IDLE on that same edge.
REQ-027 RD_ISSUE SHALL last one cycle with ram_cs=1, ram_oe=1, ram_we=0, ram_address=current address; then RD_CAPTURE.
REQ-028 RD_CAPTURE SHALL hold ram_address, drive ram_cs=ram_oe=0, and register ram_dout into rd_data at its closing edge; rd_valid high the following cycle.
REQ-029 Read beats SHALL take 2 cycles each; strobe-to-rd_valid latency SHALL be 2 cycles.
REQ-030 After the final RD_CAPTURE, state SHALL go to IDLE and rd_last SHALL accompany that rd_valid.
REQ-031 Address SHALL increment by 1 per beat modulo 2^ADDRESS_WIDTH (all-ones wraps to 0).
REQ-032 ram_we and ram_oe SHALL never be high together; ram_cs=0 SHALL imply ram_we=ram_oe=0.
REQ-033 Idle cycles SHALL drive ram_cs=ram_we=ram_oe=0; ram_address and ram_din SHALL hold last value.
REQ-034 A command accepted immediately after a write burst SHALL observe all prior writes (last write strobe precedes any new strobe).

Reset
REQ-035 rst high SHALL immediately force state IDLE and all outputs to 0 (ram_*, rd_*, wr_ready, busy); cmd_ready SHALL be 1 while rst is low and state is IDLE.
REQ-036 Reset mid-burst SHALL abandon the burst: no further RAM strobes, no rd_valid, no residual beat count after release.

Verification
REQ-037 Write cmd_addr=0x10, cmd_len=3, data 0xA1..0xA4 back-to-back -> four consecutive write strobes to 0x10..0x13, then IDLE.
REQ-038 Read cmd_addr=0x10, cmd_len=3 after REQ-037 -> rd_data 0xA1,0xA2,0xA3,0xA4 every 2 cycles, rd_last on 0xA4.
REQ-039 Write cmd_addr=0xFE, cmd_len=2 -> strobes at 0xFE, 0xFF, 0x00; readback returns same data.
REQ-040 Write burst with wr_valid gapped 2 cycles between beats -> ram_cs low during gaps, no spurious writes.
REQ-041 rst asserted during beat 2 of a 4-beat read -> outputs 0 at once, no rd_valid, next command runs normally.
REQ-042 Assertion check all runs: never ram_we && ram_oe; cmd_ready never high while busy.
